aes_key_schedule_sequencer: RTL and testbench
=============================================

# aes_key_schedule_sequencer

Sequences the AES-128 key-schedule datapath: after a start request it loads the cipher key, then steps the 4-bit inner-state counter through the decoded key-expansion steps once per round. It also tracks the round index and generates the Rcon byte. Each round key is released to the cipher core through a valid/ready handshake. It sits between the top-level AES controller and the key-schedule generator controller/datapath.

## Interface
- NUM_ROUNDS, 10, number of expanded round keys after round key 0 (AES-128)
- STEPS_PER_ROUND, 16, inner-state steps per round; the counter spans 0..STEPS_PER_ROUND-1 (max 16)
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  begin a key expansion; sampled only in IDLE
- abort  input  1  cancel the expansion in progress; priority over start
- rk_ready  input  1  consumer accepts the current round key
- key_load  output  1  one-cycle strobe: datapath loads cipher key into word registers
- step_en  output  1  datapath enable; high only in EXPAND
- inner_state_counter  output  4  step index driven to the generator controller
- round_idx  output  4  index of round key being built/emitted, 0..NUM_ROUNDS
- rcon  output  8  Rcon byte for the current expansion round
- round_key_valid  output  1  round key round_idx is stable in the datapath
- busy  output  1  high in LOAD, EMIT, EXPAND
- done  output  1  one-cycle pulse after the last round key is accepted

## Operation
- FSM states: IDLE, LOAD, EMIT, EXPAND, DONE.
- IDLE: all strobes low. start=1 and abort=0 -> LOAD.
- LOAD, one cycle:
  - key_load=1; round_idx<=0; rcon<=8'h01; inner_state_counter<=0.
  - Next state: EMIT (round key 0 is the cipher key).
- EMIT:
  - round_key_valid=1, held with round_idx stable until rk_ready=1.
  - On rk_ready with round_idx==NUM_ROUNDS -> DONE.
  - On rk_ready otherwise: round_idx<=round_idx+1; inner_state_counter<=0; -> EXPAND.
- EXPAND:
  - step_en=1; inner_state_counter increments each cycle.
  - At inner_state_counter==STEPS_PER_ROUND-1: counter <=0, rcon<=xtime(rcon), -> EMIT.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1b : 8'h00).
  - rcon during round r's EXPAND is 01,02,04,08,10,20,40,80,1b,36 for r=1..10.
- DONE: done=1 for one cycle -> IDLE. round_idx and rcon hold their final values until the next LOAD.
- Outside EXPAND, inner_state_counter is held at 0. Downstream decode is qualified by step_en.
- abort=1 in any state -> IDLE on the next edge:
  - Clears round_key_valid, step_en, key_load, busy and inner_state_counter.
  - No done pulse.
  - If start and abort are high together in IDLE, the block stays in IDLE.
- start while busy or in DONE: ignored; no queuing.
- rk_ready outside EMIT: ignored.

## Timing
- Reset values: state IDLE; all 1-bit outputs 0; inner_state_counter 0; round_idx 0; rcon 8'h01.
- Reset deasserted mid-run: the block restarts from IDLE and requires a new start.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Cycle 0: start sampled.
- Cycle 1: LOAD.
- Cycle 2: first EMIT.
- With rk_ready tied high:
  - Round key r is valid at cycle 2+17r (r=0..10); the last is at cycle 172.
  - done pulses at cycle 173; busy is low from cycle 173.
  - Total start-to-done latency is 173 cycles.
- Each cycle rk_ready is low in EMIT adds exactly one cycle to every later event.
- round_key_valid is never high in the same cycle as step_en or key_load.

## Test plan
- Nominal run, rk_ready=1:
  - start at cycle 0 -> key_load at cycle 1.
  - round_key_valid at cycles 2,19,...,172 with round_idx 0..10.
  - done at cycle 173; 160 step_en cycles total.
- Rcon sequence:
  - Sample rcon at inner_state_counter==0 in each EXPAND -> 01,02,04,08,10,20,40,80,1b,36.
  - rcon is 8'h01 during LOAD.
- Backpressure:
  - Hold rk_ready=0 for 5 cycles at round_idx=3 -> valid and round_idx held stable.
  - done shifts to cycle 178.
- Abort:
  - Assert abort at inner_state_counter=7 of round 4 -> IDLE next cycle with all outputs low and no done.
  - A following start restarts from round 0.
- Start while busy: pulse start at cycle 50 and at the DONE cycle -> no effect; done still at 173.
- Async reset: drop rst_n mid-EXPAND (between edges) -> outputs reach their reset values immediately; after release, IDLE until start.

Source files
------------

// File: rtl/aes_key_schedule_sequencer_if.sv
// Handshake/control bundle between the AES top controller (master) and the
// key-schedule sequencer (slave).
//   master drives : start, abort, rk_ready
//   slave drives  : key_load, step_en, inner_state_counter, round_idx, rcon,
//                   round_key_valid, busy, done
interface aes_key_schedule_sequencer_if;
   logic       start;
   logic       abort;
   logic       rk_ready;
   logic       key_load;
   logic       step_en;
   logic [3:0] inner_state_counter;
   logic [3:0] round_idx;
   logic [7:0] rcon;
   logic       round_key_valid;
   logic       busy;
   logic       done;

   modport master (
      output start, abort, rk_ready,
      input  key_load, step_en, inner_state_counter, round_idx, rcon,
             round_key_valid, busy, done
   );

   modport slave (
      input  start, abort, rk_ready,
      output key_load, step_en, inner_state_counter, round_idx, rcon,
             round_key_valid, busy, done
   );
endinterface

// File: rtl/aes_key_schedule_sequencer.sv
// AES-128 key-schedule sequencer. After start it strobes a cipher-key load,
// then alternates between emitting a round key (valid/ready) and stepping the
// inner-state counter through one round of key expansion, tracking round
// index and Rcon. All outputs come straight from registers.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of aes_key_schedule_sequencer_if
//
// state  | meaning
// IDLE   | waiting for start, all strobes low
// LOAD   | one cycle, key_load strobe, round/rcon/counter initialised
// EMIT   | round key round_idx valid, waiting for rk_ready
// EXPAND | step_en high, inner_state_counter sweeps 0..STEPS_PER_ROUND-1
// DONE   | one-cycle done pulse, then IDLE
module aes_key_schedule_sequencer #(
   parameter int NUM_ROUNDS      = 10,
   parameter int STEPS_PER_ROUND = 16
) (
   input logic                           clk,
   input logic                           rst_n,
   aes_key_schedule_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EMIT,
      S_EXPAND,
      S_DONE
   } state_t;

   localparam logic [3:0] LAST_STEP  = 4'(STEPS_PER_ROUND - 1);
   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   state_t     state_q;
   logic       key_load_q;
   logic       step_en_q;
   logic [3:0] cnt_q;
   logic [3:0] round_idx_q;
   logic [7:0] rcon_q;
   logic       rk_valid_q;
   logic       busy_q;
   logic       done_q;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Outputs are set on the transition into the state that owns them, so
   // every output is a plain flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         key_load_q  <= 1'b0;
         step_en_q   <= 1'b0;
         cnt_q       <= 4'd0;
         round_idx_q <= 4'd0;
         rcon_q      <= 8'h01;
         rk_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (bus.abort) begin
         // round_idx and rcon are left as they were; the next LOAD reinitialises them
         state_q    <= S_IDLE;
         key_load_q <= 1'b0;
         step_en_q  <= 1'b0;
         cnt_q      <= 4'd0;
         rk_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q     <= S_LOAD;
                  key_load_q  <= 1'b1;
                  busy_q      <= 1'b1;
                  round_idx_q <= 4'd0;
                  rcon_q      <= 8'h01;
                  cnt_q       <= 4'd0;
               end
            end
            S_LOAD: begin
               state_q    <= S_EMIT;
               key_load_q <= 1'b0;
               rk_valid_q <= 1'b1;
            end
            S_EMIT: begin
               if (bus.rk_ready) begin
                  rk_valid_q <= 1'b0;
                  if (round_idx_q == LAST_ROUND) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q     <= S_EXPAND;
                     round_idx_q <= round_idx_q + 4'd1;
                     cnt_q       <= 4'd0;
                     step_en_q   <= 1'b1;
                  end
               end
            end
            S_EXPAND: begin
               if (cnt_q == LAST_STEP) begin
                  state_q    <= S_EMIT;
                  cnt_q      <= 4'd0;
                  rcon_q     <= xtime(rcon_q);
                  step_en_q  <= 1'b0;
                  rk_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 4'd1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q    <= S_IDLE;
               key_load_q <= 1'b0;
               step_en_q  <= 1'b0;
               cnt_q      <= 4'd0;
               rk_valid_q <= 1'b0;
               busy_q     <= 1'b0;
               done_q     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.key_load            = key_load_q;
   assign bus.step_en             = step_en_q;
   assign bus.inner_state_counter = cnt_q;
   assign bus.round_idx           = round_idx_q;
   assign bus.rcon                = rcon_q;
   assign bus.round_key_valid     = rk_valid_q;
   assign bus.busy                = busy_q;
   assign bus.done                = done_q;

endmodule

// File: tb/tb_aes_key_schedule_sequencer.sv
module tb_aes_key_schedule_sequencer;
   localparam int NR     = 10;
   localparam int SPR    = 16;
   localparam int PER    = SPR + 1;          // cycles per round: one EMIT + SPR EXPAND
   localparam int T_DONE = 2 + PER * NR + 1; // elapsed (unstalled) cycles from start to done

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_key_schedule_sequencer_if bus ();

   aes_key_schedule_sequencer #(.NUM_ROUNDS(NR), .STEPS_PER_ROUND(SPR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Rcon used while building round key r is RC[r]; RC[11] is what remains after the last round.
   logic [7:0] RC [0:11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                             8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c};

   typedef struct packed {
      logic       kl;
      logic       se;
      logic [3:0] cnt;
      logic [3:0] ridx;
      logic [7:0] rcon;
      logic       rkv;
      logic       busy;
      logic       done;
   } exp_t;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   bit chk_en = 1'b0;

   // Model: progress is the count t of non-stalled cycles since start.
   bit         m_act = 1'b0;
   int         m_t = 0;
   logic [3:0] m_hr = 4'd0;
   logic [7:0] m_hc = 8'h01;

   int         done_cnt, done_rel, kl_rel, step_cnt, rkv3_cnt;
   logic [7:0] rcon_log [$];

   function automatic exp_t model_out(bit act, int t, logic [3:0] hr, logic [7:0] hc);
      exp_t e;
      int u, r, k;
      e = '0;
      e.ridx = hr;
      e.rcon = hc;
      if (!act) return e;
      if (t == 1) begin
         e.kl = 1'b1; e.busy = 1'b1; e.ridx = 4'd0; e.rcon = 8'h01;
      end else if (t == T_DONE) begin
         e.done = 1'b1; e.ridx = 4'(NR); e.rcon = RC[NR + 1];
      end else begin
         u = t - 2; r = u / PER; k = u % PER;
         e.busy = 1'b1;
         e.rcon = RC[r + 1];
         if (k == 0) begin
            e.rkv = 1'b1; e.ridx = 4'(r);
         end else begin
            e.se = 1'b1; e.ridx = 4'(r + 1); e.cnt = 4'(k - 1);
         end
      end
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_step();
      exp_t cur;
      cur = model_out(m_act, m_t, m_hr, m_hc);
      if (bus.abort) begin
         m_act = 1'b0; m_hr = cur.ridx; m_hc = cur.rcon;
      end else if (!m_act) begin
         if (bus.start) begin m_act = 1'b1; m_t = 1; start_cyc = cyc; end
      end else if (m_t == T_DONE) begin
         m_act = 1'b0; m_hr = cur.ridx; m_hc = cur.rcon;
      end else if (!(cur.rkv && !bus.rk_ready)) begin
         m_t++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic step(input bit s, input bit a, input bit r);
      bus.start = s; bus.abort = a; bus.rk_ready = r;
      tick();
   endtask

   task automatic clear_logs();
      done_cnt = 0; done_rel = -1; kl_rel = -1; step_cnt = 0; rkv3_cnt = 0;
      rcon_log.delete();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_key_load"}, bus.key_load, 0);
      chk({tag, "_step_en"}, bus.step_en, 0);
      chk({tag, "_cnt"}, bus.inner_state_counter, 0);
      chk({tag, "_round_idx"}, bus.round_idx, 0);
      chk({tag, "_rcon"}, bus.rcon, 8'h01);
      chk({tag, "_valid"}, bus.round_key_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
   endtask

   // Single per-cycle comparison against the model, plus event logging.
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         exp_t e;
         e = model_out(m_act, m_t, m_hr, m_hc);
         chk("key_load", bus.key_load, e.kl);
         chk("step_en", bus.step_en, e.se);
         chk("inner_state_counter", bus.inner_state_counter, e.cnt);
         chk("round_idx", bus.round_idx, e.ridx);
         chk("rcon", bus.rcon, e.rcon);
         chk("round_key_valid", bus.round_key_valid, e.rkv);
         chk("busy", bus.busy, e.busy);
         chk("done", bus.done, e.done);
         if (bus.done) begin done_cnt++; done_rel = cyc - start_cyc; end
         if (bus.key_load) kl_rel = cyc - start_cyc;
         if (bus.step_en) step_cnt++;
         if (bus.step_en && bus.inner_state_counter == 4'd0) rcon_log.push_back(bus.rcon);
         if (bus.round_key_valid && bus.round_idx == 4'd3) rkv3_cnt++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_rc;
      bus.start = 1'b0; bus.abort = 1'b0; bus.rk_ready = 1'b0;
      #22;
      chk_reset_vals("reset");
      #1 rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (3) step(0, 0, 1);

      // start and abort together in IDLE: stays idle
      step(1, 1, 1);
      chk("start_abort_idle_busy", bus.busy, 0);
      chk("start_abort_idle_key_load", bus.key_load, 0);
      step(0, 0, 0);

      // Nominal run with stray starts at cycle 50 and in the DONE cycle
      clear_logs();
      step(1, 0, 1);
      for (int i = 1; i < 185; i++) step((i == 50) || (i == T_DONE), 0, 1);
      chk("nominal_key_load_cycle", kl_rel, 1);
      chk("nominal_done_cycle", done_rel, 173);
      chk("nominal_done_count", done_cnt, 1);
      chk("nominal_step_en_cycles", step_cnt, 160);
      chk("nominal_rcon_samples", rcon_log.size(), 10);
      for (int r = 0; r < 10 && r < rcon_log.size(); r++) begin
         case (r)
            0: exp_rc = 8'h01; 1: exp_rc = 8'h02; 2: exp_rc = 8'h04; 3: exp_rc = 8'h08;
            4: exp_rc = 8'h10; 5: exp_rc = 8'h20; 6: exp_rc = 8'h40; 7: exp_rc = 8'h80;
            8: exp_rc = 8'h1b; default: exp_rc = 8'h36;
         endcase
         chk("nominal_rcon_round", rcon_log[r], exp_rc);
      end

      // Backpressure: rk_ready low for 5 cycles while round key 3 is offered
      clear_logs();
      step(1, 0, 1);
      for (int i = 1; i < 190; i++) step(0, 0, !(i >= 53 && i <= 57));
      chk("backpressure_done_cycle", done_rel, 178);
      chk("backpressure_rk3_valid_cycles", rkv3_cnt, 6);

      // Abort at counter 7 of round 4
      clear_logs();
      step(1, 0, 1);
      for (int i = 1; i < 61; i++) step(0, 0, 1);
      chk("abort_point_cnt", bus.inner_state_counter, 7);
      chk("abort_point_round", bus.round_idx, 4);
      step(0, 1, 1);
      chk("abort_busy", bus.busy, 0);
      chk("abort_step_en", bus.step_en, 0);
      chk("abort_valid", bus.round_key_valid, 0);
      chk("abort_key_load", bus.key_load, 0);
      chk("abort_cnt", bus.inner_state_counter, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 1);
      chk("abort_no_done", done_cnt, 0);
      clear_logs();
      step(1, 0, 1);
      chk("restart_key_load", bus.key_load, 1);
      chk("restart_round_idx", bus.round_idx, 0);
      chk("restart_rcon", bus.rcon, 8'h01);
      for (int i = 1; i < 180; i++) step(0, 0, 1);
      chk("restart_done_cycle", done_rel, 173);

      // Async reset mid-EXPAND, applied between clock edges
      clear_logs();
      step(1, 0, 1);
      for (int i = 1; i < 30; i++) step(0, 0, 1);
      chk("prereset_step_en", bus.step_en, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("async_reset");
      m_act = 1'b0; m_hr = 4'd0; m_hc = 8'h01;
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(0, 0, 1);
      chk("post_reset_idle_busy", bus.busy, 0);
      clear_logs();
      step(1, 0, 1);
      for (int i = 1; i < 180; i++) step(0, 0, 1);
      chk("post_reset_done_cycle", done_rel, 173);

      // Randomized runs: random backpressure, stray starts, rare aborts
      for (int run = 0; run < 6; run++) begin
         step(1, 0, 1);
         for (int i = 0; i < 700; i++) begin
            if (!m_act) break;
            step($urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 3) != 0);
         end
         chk("random_run_finished", m_act, 0);
         repeat (3) step(0, 0, $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
